// File: rtl/pipeline_debug_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_debug_pkg
// Shared definitions for the pipeline debug link command sequencer:
//   - dbg_state_e   : command FSM states
//   - CMD_*         : ASCII command bytes accepted from the UART receiver
//   - DEFAULT_HDR_BYTE : header byte written before every snapshot dump
//   - word_byte()   : byte lane select used when serialising 32-bit words
// -----------------------------------------------------------------------------
package pipeline_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_SETTLE,
    ST_RUN,
    ST_DUMP
  } dbg_state_e;

  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'

  localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

  // Byte lane idx of a word, lane 0 being the least-significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/pipeline_debug_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_debug_ctrl_if
// Transmit/snapshot bus between the debug sequencer and its neighbours:
//   fifo_full  : transmit FIFO full (FIFO -> sequencer)
//   fifo_wr_en : one-cycle write strobe (sequencer -> FIFO)
//   fifo_din   : byte to write, valid with fifo_wr_en
//   snap_sel   : index of requested snapshot word (sequencer -> mux)
//   snap_word  : selected snapshot word, combinational from snap_sel
// Modports: master = sequencer side, slave = FIFO/mux side.
// -----------------------------------------------------------------------------
interface pipeline_debug_ctrl_if;

  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [3:0]  snap_sel;
  logic [31:0] snap_word;

  modport master (
    input  fifo_full,
    input  snap_word,
    output fifo_wr_en,
    output fifo_din,
    output snap_sel
  );

  modport slave (
    output fifo_full,
    output snap_word,
    input  fifo_wr_en,
    input  fifo_din,
    input  snap_sel
  );

endinterface

// File: rtl/pipeline_debug_ctrl_serializer.sv
// -----------------------------------------------------------------------------
// dbg_byte_serializer
// Streams one snapshot dump into the transmit FIFO: the header byte, then
// words 0..NUM_WORDS-1 as 4 bytes each, least-significant byte first.
// Honours fifo_full by holding its counters; no byte is lost or duplicated.
// Optional feature (macro PIPE_DBG_CYCLE_CNT_EN): one extra word, the
// pipeline cycle counter, is appended after the last snapshot word.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : begin a dump on this edge (header goes out immediately
//                   unless the FIFO is full)
//   cycle_cnt_i   : cycle counter word (only with PIPE_DBG_CYCLE_CNT_EN)
//   active_o      : a dump is in progress (registered)
//   tx            : FIFO write and snapshot mux bus (master side)
// -----------------------------------------------------------------------------
module dbg_byte_serializer
  import pipeline_debug_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 8,
  parameter logic [7:0]  HDR_BYTE  = DEFAULT_HDR_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
`ifdef PIPE_DBG_CYCLE_CNT_EN
  input  logic [31:0] cycle_cnt_i,
`endif
  output logic        active_o,
  pipeline_debug_ctrl_if.master tx
);

  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

  logic       active_q, active_d;
  logic       hdr_q,    hdr_d;     // header still to be written
  logic [3:0] word_q,   word_d;    // doubles as snap_sel
  logic [1:0] byte_q,   byte_d;
  logic       wr_en_q,  wr_en_d;
  logic [7:0] din_q,    din_d;
`ifdef PIPE_DBG_CYCLE_CNT_EN
  logic       cnt_word_q, cnt_word_d;  // currently sending the counter word
`endif

  // A start on this edge behaves as if the dump were already active with the
  // header pending, so the header can go out in the first DUMP cycle.
  logic        cur_active;
  logic        cur_hdr;
  logic [3:0]  cur_word;
  logic [1:0]  cur_byte;
  logic        cur_cnt;
  logic        emit;
  logic [31:0] src_word;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cur_active = active_q | start_i;
    cur_hdr    = start_i | hdr_q;
    cur_word   = start_i ? 4'd0 : word_q;
    cur_byte   = start_i ? 2'd0 : byte_q;
`ifdef PIPE_DBG_CYCLE_CNT_EN
    cur_cnt    = start_i ? 1'b0 : cnt_word_q;
    src_word   = cur_cnt ? cycle_cnt_i : tx.snap_word;
    cnt_word_d = cur_cnt;
`else
    cur_cnt    = 1'b0;
    src_word   = tx.snap_word;
`endif
    emit     = cur_active & ~tx.fifo_full;

    active_d = cur_active;
    hdr_d    = cur_hdr;
    word_d   = cur_word;
    byte_d   = cur_byte;
    wr_en_d  = emit;
    din_d    = din_q;

    if (emit) begin
      if (cur_hdr) begin
        din_d = HDR_BYTE;
        hdr_d = 1'b0;
      end else begin
        din_d  = word_byte(src_word, cur_byte);
        byte_d = cur_byte + 2'd1;
        if (cur_byte == 2'd3) begin
`ifdef PIPE_DBG_CYCLE_CNT_EN
          if (cur_cnt) begin
            cnt_word_d = 1'b0;
            active_d   = 1'b0;
            word_d     = 4'd0;
          end else if (cur_word == LAST_WORD) begin
            cnt_word_d = 1'b1;
            word_d     = 4'd0;
          end else begin
            word_d = cur_word + 4'd1;
          end
`else
          // Word index returns to 0 at the end so snap_sel idles at 0; this
          // also covers NUM_WORDS=16 where the 4-bit index would wrap anyway.
          if (cur_word == LAST_WORD) begin
            active_d = 1'b0;
            word_d   = 4'd0;
          end else begin
            word_d = cur_word + 4'd1;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      hdr_q    <= 1'b0;
      word_q   <= 4'd0;
      byte_q   <= 2'd0;
      wr_en_q  <= 1'b0;
      din_q    <= 8'd0;
`ifdef PIPE_DBG_CYCLE_CNT_EN
      cnt_word_q <= 1'b0;
`endif
    end else begin
      active_q <= active_d;
      hdr_q    <= hdr_d;
      word_q   <= word_d;
      byte_q   <= byte_d;
      wr_en_q  <= wr_en_d;
      din_q    <= din_d;
`ifdef PIPE_DBG_CYCLE_CNT_EN
      cnt_word_q <= cnt_word_d;
`endif
    end
  end

  assign tx.fifo_wr_en = wr_en_q;
  assign tx.fifo_din   = din_q;
  assign tx.snap_sel   = word_q;
  assign active_o      = active_q;

  logic unused_cur_cnt;
  assign unused_cur_cnt = cur_cnt;

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_debug_ctrl
// Command sequencer for the pipeline debug link. Decodes single-byte ASCII
// commands ('S' step, 'R' run, 'H' halt, 'D' dump) from the UART receiver,
// gates the pipeline clock enable, and after a step or halt dumps a fixed
// list of 32-bit snapshot words into the transmit FIFO.
// Optional feature, macro PIPE_DBG_CYCLE_CNT_EN: a 32-bit count of
// pipe_clk_en cycles is appended to every dump as one extra word.
//
// Parameters: NUM_WORDS (1..16) snapshot words per dump, HDR_BYTE header.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx_data      : received byte, valid while rx_data_rdy is high
//   rx_data_rdy  : receiver level strobe; only its rising edge is used
//   tx           : FIFO write / snapshot mux bus (master side)
//   pipe_clk_en  : pipeline advances one cycle per clk it is high
//   busy         : high in every state except IDLE
// -----------------------------------------------------------------------------
module pipeline_debug_ctrl
  import pipeline_debug_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 8,
  parameter logic [7:0]  HDR_BYTE  = DEFAULT_HDR_BYTE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_rdy,
  pipeline_debug_ctrl_if.master tx,
  output logic       pipe_clk_en,
  output logic       busy
);

  // ---------------------------------------------------------------------------
  // Receive edge detect: the command is registered together with its strobe,
  // so the FSM acts one edge after the rising edge of rx_data_rdy is seen.
  // ---------------------------------------------------------------------------
  logic       rx_rdy_q;
  logic       cmd_vld_q;
  logic [7:0] cmd_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_rdy_q  <= 1'b0;
      cmd_vld_q <= 1'b0;
      cmd_q     <= 8'd0;
    end else begin
      rx_rdy_q  <= rx_data_rdy;
      cmd_vld_q <= rx_data_rdy & ~rx_rdy_q;
      if (rx_data_rdy && !rx_rdy_q) begin
        cmd_q <= rx_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------------
  dbg_state_e state_q;
  logic       pipe_clk_en_q;
  logic       busy_q;
  logic       ser_active;

  logic accept_step, accept_run, accept_dump, accept_halt, dump_start;

  // A command pulse outside IDLE (other than 'H' in RUN) simply matches none
  // of these and is dropped.
  assign accept_step = (state_q == ST_IDLE) && cmd_vld_q && (cmd_q == CMD_STEP);
  assign accept_run  = (state_q == ST_IDLE) && cmd_vld_q && (cmd_q == CMD_RUN);
  assign accept_dump = (state_q == ST_IDLE) && cmd_vld_q && (cmd_q == CMD_DUMP);
  assign accept_halt = (state_q == ST_RUN)  && cmd_vld_q && (cmd_q == CMD_HALT);
  assign dump_start  = accept_dump || (state_q == ST_SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pipe_clk_en_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_step) begin
            state_q       <= ST_STEP;
            pipe_clk_en_q <= 1'b1;
            busy_q        <= 1'b1;
          end else if (accept_run) begin
            state_q       <= ST_RUN;
            pipe_clk_en_q <= 1'b1;
            busy_q        <= 1'b1;
          end else if (accept_dump) begin
            state_q <= ST_DUMP;
            busy_q  <= 1'b1;
          end
        end
        ST_STEP: begin
          state_q       <= ST_SETTLE;
          pipe_clk_en_q <= 1'b0;
        end
        ST_SETTLE: begin
          state_q <= ST_DUMP;
        end
        ST_RUN: begin
          if (accept_halt) begin
            state_q       <= ST_SETTLE;
            pipe_clk_en_q <= 1'b0;
          end
        end
        ST_DUMP: begin
          // The serializer drops active on the edge that emits the last byte,
          // so DUMP (and busy) covers the cycle in which that byte is written.
          if (!ser_active) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          pipe_clk_en_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign pipe_clk_en = pipe_clk_en_q;
  assign busy        = busy_q;

`ifdef PIPE_DBG_CYCLE_CNT_EN
  // Counts pipeline cycles since reset; wraps naturally at 2^32.
  logic [31:0] cyc_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= 32'd0;
    end else if (pipe_clk_en_q) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end
`endif

  dbg_byte_serializer #(
    .NUM_WORDS (NUM_WORDS),
    .HDR_BYTE  (HDR_BYTE)
  ) u_serializer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (dump_start),
`ifdef PIPE_DBG_CYCLE_CNT_EN
    .cycle_cnt_i (cyc_cnt_q),
`endif
    .active_o    (ser_active),
    .tx          (tx)
  );

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_debug_ctrl
// Self-checking bench for pipeline_debug_ctrl (NUM_WORDS=8, HDR_BYTE=A5).
// Expected dumps are built from the snapshot table and the command history;
// expected timing follows the documented edge-to-output latencies.
// Honours PIPE_DBG_CYCLE_CNT_EN when compiled with it.
// -----------------------------------------------------------------------------
module tb_pipeline_debug_ctrl;
  import pipeline_debug_pkg::*;

  localparam int NW = 8;
  localparam logic [7:0] HDR = 8'hA5;
`ifdef PIPE_DBG_CYCLE_CNT_EN
  localparam int DUMP_WORDS = NW + 1;
`else
  localparam int DUMP_WORDS = NW;
`endif
  localparam int DUMP_LEN = 1 + 4 * DUMP_WORDS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_data_rdy = 1'b0;
  logic       pipe_clk_en;
  logic       busy;

  pipeline_debug_ctrl_if tx_if ();

  logic [31:0] snap_mem [16];
  assign tx_if.snap_word = snap_mem[tx_if.snap_sel];

  pipeline_debug_ctrl #(
    .NUM_WORDS (NW),
    .HDR_BYTE  (HDR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_data_rdy (rx_data_rdy),
    .tx          (tx_if),
    .pipe_clk_en (pipe_clk_en),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, away from the active edge.
  logic [7:0] got_q [$];
  int         got_cyc [$];
  int         pipe_cnt, pipe_first, pipe_last, busy_cnt;

  always @(negedge clk) begin
    if (tx_if.fifo_wr_en) begin
      got_q.push_back(tx_if.fifo_din);
      got_cyc.push_back(cyc);
    end
    if (pipe_clk_en) begin
      if (pipe_cnt == 0) pipe_first = cyc;
      pipe_last = cyc;
      pipe_cnt++;
    end
    if (busy) busy_cnt++;
  end

  // Reference model state
  logic [7:0]  exp_q [$];
  logic [31:0] exp_pipe_total;
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void build_exp();
    exp_q.delete();
    exp_q.push_back(HDR);
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'(snap_mem[w] >> (8 * b)));
`ifdef PIPE_DBG_CYCLE_CNT_EN
    for (int b = 0; b < 4; b++)
      exp_q.push_back(8'(exp_pipe_total >> (8 * b)));
`endif
  endfunction

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic randomize_mem(input bit plan_pattern);
    for (int i = 0; i < 16; i++)
      snap_mem[i] = plan_pattern ? 32'h1000_0000 + 32'(i) : $urandom;
  endtask

  task automatic clear_mon();
    @(posedge clk); #1;
    got_q.delete();
    got_cyc.delete();
    pipe_cnt = 0; busy_cnt = 0; pipe_first = -1; pipe_last = -1;
  endtask

  // Returns the edge index at which the rising strobe is first sampled.
  task automatic drive_cmd(input logic [7:0] b, input int hold, output int n_edge);
    @(posedge clk); #1;
    rx_data = b;
    rx_data_rdy = 1'b1;
    n_edge = cyc + 1;
    repeat (hold) @(posedge clk);
    #1;
    rx_data_rdy = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic wait_idle(input int from, output int idle_at);
    idle_at = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cyc >= from && !busy) begin
        idle_at = cyc;
        break;
      end
    end
  endtask

  task automatic check_dump(input string name);
    int d;
    n_checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s length: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
    else n_pass++;
    d = first_diff();
    n_checks++;
    if (d != -1)
      $display("FAIL %s byte[%0d]: got %02h, expected %02h", name, d, got_q[d], exp_q[d]);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_if.fifo_wr_en, tx_if.fifo_din, tx_if.snap_sel, pipe_clk_en, busy} !== 15'd0)
      $display("FAIL reset outputs during reset: got %h, expected 0",
               {tx_if.fifo_wr_en, tx_if.fifo_din, tx_if.snap_sel, pipe_clk_en, busy});
    else n_pass++;
    rst_n = 1'b1;
    exp_pipe_total = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_if.fifo_wr_en, tx_if.fifo_din, tx_if.snap_sel, pipe_clk_en, busy} !== 15'd0)
      $display("FAIL reset outputs after release: got %h, expected 0",
               {tx_if.fifo_wr_en, tx_if.fifo_din, tx_if.snap_sel, pipe_clk_en, busy});
    else n_pass++;
  endtask

  task automatic test_step_dump();
    int n, idle;
    randomize_mem(1'b1);
    clear_mon();
    drive_cmd(CMD_STEP, 1, n);
    exp_pipe_total += 32'd1;
    build_exp();
    wait_idle(n + 1, idle);
    n_checks++;
    if (pipe_cnt !== 1 || pipe_first !== n + 1)
      $display("FAIL step pulse: got %0d pulses first at %0d, expected 1 at %0d", pipe_cnt, pipe_first, n + 1);
    else n_pass++;
    n_checks++;
    if ((got_cyc.size() > 0 ? got_cyc[0] : -1) !== n + 3)
      $display("FAIL step header latency: got cycle %0d, expected %0d",
               got_cyc.size() > 0 ? got_cyc[0] : -1, n + 3);
    else n_pass++;
    n_checks++;
    if (idle !== n + 3 + DUMP_LEN)
      $display("FAIL step idle cycle: got %0d, expected %0d", idle, n + 3 + DUMP_LEN);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== DUMP_LEN + 2)
      $display("FAIL step busy cycles: got %0d, expected %0d", busy_cnt, DUMP_LEN + 2);
    else n_pass++;
    check_dump("step dump");
  endtask

  task automatic test_run_halt();
    int n, m, junk, idle;
    randomize_mem(1'b0);
    clear_mon();
    drive_cmd(CMD_RUN, 1, n);
    repeat (40) @(posedge clk);
    drive_cmd(CMD_STEP, 1, junk);   // ignored while running
    repeat (10) @(posedge clk);
    drive_cmd(CMD_DUMP, 2, junk);   // ignored while running
    repeat ($urandom_range(40, 55)) @(posedge clk);
    drive_cmd(CMD_HALT, 1, m);
    exp_pipe_total += 32'(m - n);
    build_exp();
    wait_idle(n + 1, idle);
    n_checks++;
    if (pipe_cnt !== m - n || pipe_first !== n + 1 || pipe_last !== m)
      $display("FAIL run pipe_clk_en: got %0d cycles [%0d..%0d], expected %0d [%0d..%0d]",
               pipe_cnt, pipe_first, pipe_last, m - n, n + 1, m);
    else n_pass++;
    n_checks++;
    if (idle !== m + 2 + DUMP_LEN)
      $display("FAIL run idle cycle: got %0d, expected %0d", idle, m + 2 + DUMP_LEN);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== idle - (n + 1))
      $display("FAIL run busy continuity: got %0d busy cycles, expected %0d", busy_cnt, idle - (n + 1));
    else n_pass++;
    check_dump("halt dump");
  endtask

  task automatic test_fifo_full();
    int n, idle, gap;
    randomize_mem(1'b0);
    clear_mon();
    drive_cmd(CMD_DUMP, 1, n);
    build_exp();
    for (int i = 0; i < 200 && got_q.size() < 11; i++) @(negedge clk);
    @(posedge clk); #1;
    tx_if.fifo_full = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tx_if.fifo_full = 1'b0;
    wait_idle(n + 1, idle);
    gap = (got_cyc.size() > 0) ? (got_cyc[got_cyc.size() - 1] - got_cyc[0] + 1 - got_cyc.size()) : -1;
    n_checks++;
    if (gap !== 5)
      $display("FAIL stall gap: got %0d idle write cycles, expected 5", gap);
    else n_pass++;
    n_checks++;
    if (idle !== n + 1 + DUMP_LEN + 5)
      $display("FAIL stall idle cycle: got %0d, expected %0d", idle, n + 1 + DUMP_LEN + 5);
    else n_pass++;
    check_dump("stalled dump");
  endtask

  task automatic test_drop_and_hold();
    int n, junk, idle, sz;
    randomize_mem(1'b0);
    clear_mon();
    drive_cmd(CMD_DUMP, 1, n);
    repeat ($urandom_range(3, 20)) @(posedge clk);
    drive_cmd(CMD_STEP, 1, junk);   // dropped: DUMP in progress
    build_exp();
    wait_idle(n + 1, idle);
    n_checks++;
    if (idle !== n + 1 + DUMP_LEN)
      $display("FAIL drop idle cycle: got %0d, expected %0d", idle, n + 1 + DUMP_LEN);
    else n_pass++;
    sz = got_q.size();
    repeat (20) @(negedge clk);
    n_checks++;
    if (pipe_cnt !== 0 || busy !== 1'b0 || got_q.size() !== sz)
      $display("FAIL drop queued command: got %0d pulses busy=%b bytes %0d->%0d, expected 0 pulses idle no bytes",
               pipe_cnt, busy, sz, got_q.size());
    else n_pass++;
    check_dump("drop dump");

    clear_mon();
    drive_cmd(CMD_STEP, 10, n);
    exp_pipe_total += 32'd1;
    build_exp();
    wait_idle(n + 1, idle);
    repeat (10) @(negedge clk);
    n_checks++;
    if (pipe_cnt !== 1 || idle !== n + 3 + DUMP_LEN)
      $display("FAIL held strobe: got %0d pulses idle at %0d, expected 1 pulse idle at %0d",
               pipe_cnt, idle, n + 3 + DUMP_LEN);
    else n_pass++;
    check_dump("held strobe dump");
  endtask

  task automatic test_ignored();
    int junk;
    logic [7:0] b;
    clear_mon();
    drive_cmd(CMD_HALT, 1, junk);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      if (b == CMD_STEP || b == CMD_RUN || b == CMD_DUMP) b = 8'h00;
      repeat (2) @(posedge clk);
      drive_cmd(b, 1, junk);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy_cnt !== 0 || pipe_cnt !== 0 || got_q.size() !== 0)
      $display("FAIL ignored bytes: got busy %0d pulses %0d bytes %0d, expected all 0",
               busy_cnt, pipe_cnt, got_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_dump();
    int n, idle;
    randomize_mem(1'b0);
    clear_mon();
    drive_cmd(CMD_DUMP, 1, n);
    for (int i = 0; i < 200 && got_q.size() < 12; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_if.fifo_wr_en, tx_if.fifo_din, tx_if.snap_sel, pipe_clk_en, busy} !== 15'd0)
      $display("FAIL mid-dump reset outputs: got %h, expected 0",
               {tx_if.fifo_wr_en, tx_if.fifo_din, tx_if.snap_sel, pipe_clk_en, busy});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pipe_total = 32'd0;
    randomize_mem(1'b0);
    clear_mon();
    drive_cmd(CMD_DUMP, 1, n);
    build_exp();
    wait_idle(n + 1, idle);
    n_checks++;
    if (idle !== n + 1 + DUMP_LEN)
      $display("FAIL post-reset idle cycle: got %0d, expected %0d", idle, n + 1 + DUMP_LEN);
    else n_pass++;
    check_dump("post-reset dump");
  endtask

  task automatic test_back_to_back();
    int n, idle;
    logic [31:0] tail;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    exp_pipe_total = 32'd0;
    for (int k = 0; k < 3; k++) begin
      randomize_mem(1'b0);
      clear_mon();
      drive_cmd(CMD_STEP, 1, n);
      exp_pipe_total += 32'd1;
      build_exp();
      wait_idle(n + 1, idle);
      n_checks++;
      if (pipe_cnt !== 1 || idle !== n + 3 + DUMP_LEN)
        $display("FAIL back-to-back step %0d: got %0d pulses idle at %0d, expected 1 idle at %0d",
                 k, pipe_cnt, idle, n + 3 + DUMP_LEN);
      else n_pass++;
      check_dump("back-to-back dump");
    end
`ifdef PIPE_DBG_CYCLE_CNT_EN
    tail = 'x;
    if (got_q.size() >= 4)
      tail = {got_q[got_q.size() - 1], got_q[got_q.size() - 2],
              got_q[got_q.size() - 3], got_q[got_q.size() - 4]};
    n_checks++;
    if (tail !== 32'd3 || got_q.size() !== 37)
      $display("FAIL cycle counter word: got %h len %0d, expected 00000003 len 37", tail, got_q.size());
    else n_pass++;
`else
    tail = 32'd0;
`endif
  endtask

  initial begin
    tx_if.fifo_full = 1'b0;
    exp_pipe_total  = 32'd0;
    randomize_mem(1'b1);
    test_reset();
    test_step_dump();
    test_run_halt();
    test_fifo_full();
    test_drop_and_hold();
    test_ignored();
    test_reset_mid_dump();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
